// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the memory-access stage of the RV32 core.
//
// Contents:
//   ex_mem_t     EX/MEM register bundle consumed by the MEM stage
//   mem_wb_t     MEM/WB register bundle produced for write-back
//   RES_*        result-select encodings carried in ex_mem_t.resultsrc
//   mem_state_t  data-memory interface FSM states
//   FAULT_*      fault cause encodings
//   helpers      access / alignment classification
package mem_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_AW     = 5;
    localparam int unsigned RES_W      = 2;
    // Wide enough for the largest legal MAX_WAIT (255).
    localparam int unsigned WAIT_CNT_W = 8;

    localparam logic [RES_W-1:0] RES_ALU = 2'b00;
    localparam logic [RES_W-1:0] RES_MEM = 2'b01;
    localparam logic [RES_W-1:0] RES_PC4 = 2'b10;

    localparam logic FAULT_MISALIGNED = 1'b0;
    localparam logic FAULT_TIMEOUT    = 1'b1;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_RSP = 1'b1
    } mem_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   aluresult;
        logic [XLEN-1:0]   writedata;
        logic [XLEN-1:0]   pcplus4;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
        logic [RES_W-1:0]  resultsrc;
        logic              memwrite;
    } ex_mem_t;

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [REG_AW-1:0] rd;
        logic              regwrite;
    } mem_wb_t;

    // A real instruction that touches data memory (load or store).
    function automatic logic is_access(input ex_mem_t x, input logic valid);
        return valid && (x.memwrite || (x.resultsrc == RES_MEM));
    endfunction

    // Only word accesses exist, so any low address bit set is misaligned.
    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_if_fsm.sv
// Data-memory bus interface for the MEM stage.
//
// Runs one word access at a time on a request/grant/response bus, counts
// response wait cycles, and reports completion, load data and fault codes.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   access              a real load/store is presented this cycle
//   store               1 = store, 0 = load (valid with access)
//   addr, wdata         access address and store data
//   dmem_req/we/addr/wdata  bus request side (combinational)
//   dmem_gnt            bus accepted the request this cycle
//   dmem_rvalid/rdata   load response
//   done                access completes at the next rising edge
//   rdata               load data (0 unless a response is present)
//   fault_valid         completing access is faulting
//   fault_cause         FAULT_MISALIGNED or FAULT_TIMEOUT
module dmem_if_fsm
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            access,
    input  logic            store,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            done,
    output logic [XLEN-1:0] rdata,
    output logic            fault_valid,
    output logic            fault_cause
);

    // Counter value of the last permitted wait cycle.
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    mem_state_t            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  misaligned;
    logic                  load_granted;

    assign misaligned   = is_misaligned(addr);
    assign load_granted = (state == ST_IDLE) && rst_n && access && !misaligned
                          && !store && dmem_gnt;

    // Bus drive, completion and fault decode for the current state.
    always_comb begin
        dmem_req    = 1'b0;
        dmem_we     = store;
        dmem_addr   = addr;
        dmem_wdata  = wdata;
        done        = 1'b0;
        rdata       = '0;
        fault_valid = 1'b0;
        fault_cause = FAULT_MISALIGNED;
        case (state)
            ST_IDLE: begin
                // Gated by rst_n so no request escapes while reset is held.
                if (access && rst_n) begin
                    if (misaligned) begin
                        done        = 1'b1;
                        fault_valid = 1'b1;
                        fault_cause = FAULT_MISALIGNED;
                    end else begin
                        dmem_req = 1'b1;
                        done     = store && dmem_gnt;
                    end
                end
            end
            ST_WAIT_RSP: begin
                // A response on the last wait cycle still wins over the abort.
                if (dmem_rvalid) begin
                    done  = 1'b1;
                    rdata = dmem_rdata;
                end else if (wait_cnt == WAIT_LAST) begin
                    done        = 1'b1;
                    fault_valid = 1'b1;
                    fault_cause = FAULT_TIMEOUT;
                end
            end
            default: begin
                done = 1'b0;
            end
        endcase
    end

    // State and wait counter; responses seen in IDLE are simply not looked at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_granted) begin
                        state    <= ST_WAIT_RSP;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT_RSP: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage of the five-stage RV32 core.
//
// Issues word loads/stores from the EX/MEM bundle on the data-memory bus,
// stalls the front of the pipe while an access is outstanding, and
// registers the MEM/WB bundle (bubbling WB until the access completes).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in, in_valid      EX/MEM bundle and its valid bit
//   stall_m           freeze F/D/E and EX/MEM this cycle (combinational)
//   out, out_valid    registered MEM/WB bundle and its valid bit
//   dmem_*            data-memory request/grant/response bus
//   fault             registered one-cycle pulse on a faulting access
//   fault_cause       0 = misaligned, 1 = load timeout (valid with fault)
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  ex_mem_t         in,
    input  logic            in_valid,
    output logic            stall_m,
    output mem_wb_t         out,
    output logic            out_valid,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            fault,
    output logic            fault_cause
);

    logic            access;
    logic            done;
    logic [XLEN-1:0] load_data;
    logic            acc_fault;
    logic            acc_cause;
    logic [XLEN-1:0] result_sel;

    assign access = is_access(in, in_valid);

    dmem_if_fsm #(
        .MAX_WAIT(MAX_WAIT)
    ) u_dmem_if_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .access      (access),
        .store       (in.memwrite),
        .addr        (in.aluresult),
        .wdata       (in.writedata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .done        (done),
        .rdata       (load_data),
        .fault_valid (acc_fault),
        .fault_cause (acc_cause)
    );

    // Pending access not finishing this cycle; never asserted under reset.
    assign stall_m = rst_n && access && !done;

    // Write-back result select; a timed-out load yields 0 via load_data.
    always_comb begin
        result_sel = in.aluresult;
        case (in.resultsrc)
            RES_ALU: result_sel = in.aluresult;
            RES_MEM: result_sel = load_data;
            RES_PC4: result_sel = in.pcplus4;
            default: result_sel = in.aluresult;
        endcase
    end

    // MEM/WB register: capture when not stalled, otherwise hold and bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out         <= '0;
            out_valid   <= 1'b0;
            fault       <= 1'b0;
            fault_cause <= FAULT_MISALIGNED;
        end else if (!stall_m) begin
            out.result   <= result_sel;
            out.rd       <= in.rd;
            out.regwrite <= in.regwrite && !acc_fault;
            out_valid    <= in_valid;
            fault        <= acc_fault;
            if (acc_fault) begin
                fault_cause <= acc_cause;
            end
        end else begin
            out_valid <= 1'b0;
            fault     <= 1'b0;
        end
    end

endmodule
